// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch tick controller: FSM state encoding,
// default prescaler divide ratio and a small state-decoding helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int DIV_DEFAULT = 100000;

    function automatic logic is_running(input state_t st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Push-button conditioning: two-flop synchronizer followed by a rising-edge
// detector. A button already high when reset releases never yields an event.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic       sync1_r;
    logic       sync2_r;
    logic       prev_r;
    logic [2:0] ready_r;

    // Synchronizer, delayed copy for edge detection, and a warm-up mask that
    // stays low until the delayed copy holds a genuine post-reset sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            ready_r <= 3'b000;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            ready_r <= {ready_r[1:0], 1'b1};
        end
    end

    assign rise = sync2_r & ~prev_r & ready_r[2];

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch control: button events drive an IDLE/RUN/PAUSE/LAP machine and a
// prescaler producing a one-cycle tick every DIV running cycles.
module stopwatch_tick_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic       tick,
    output logic       clr_digits,
    output logic       running,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic          start_ev_s;
    logic          lap_ev_s;
    logic          clear_ev_s;
    logic          clear_win_s;
    logic          start_win_s;
    logic          lap_win_s;
    logic          to_idle_s;
    logic          advance_s;
    logic          cnt_last_s;
    state_t        next_state_s;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          tick_r;
    logic          clr_r;
    logic          running_r;
    logic          lap_hold_r;

    btn_edge u_start (.clk(clk), .rst_n(reset), .btn(start_stop), .rise(start_ev_s));
    btn_edge u_lap   (.clk(clk), .rst_n(reset), .btn(lap),        .rise(lap_ev_s));
    btn_edge u_clear (.clk(clk), .rst_n(reset), .btn(clear),      .rise(clear_ev_s));

    // Pick the single winning event (clear > start > lap, losers dropped even
    // if the winner is ignored in the current state) and derive next state.
    always_comb begin
        clear_win_s  = clear_ev_s;
        start_win_s  = start_ev_s & ~clear_ev_s;
        lap_win_s    = lap_ev_s & ~start_ev_s & ~clear_ev_s;
        next_state_s = state_r;
        to_idle_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_win_s) begin
                    to_idle_s = 1'b1;
                end else if (start_win_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_win_s) begin
                    next_state_s = ST_PAUSE;
                end else if (lap_win_s) begin
                    next_state_s = ST_LAP;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (start_win_s) begin
                    next_state_s = ST_PAUSE;
                end else if (lap_win_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (clear_win_s) begin
                    next_state_s = ST_IDLE;
                    to_idle_s    = 1'b1;
                end else if (start_win_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_PAUSE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        // A start event leaving RUN/LAP freezes the prescaler on that edge.
        advance_s  = is_running(state_r) & ~start_win_s;
        cnt_last_s = (cnt_r == LAST);
    end

    // FSM state, prescaler and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            tick_r     <= 1'b0;
            clr_r      <= 1'b0;
            running_r  <= 1'b0;
            lap_hold_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            running_r  <= is_running(next_state_s);
            lap_hold_r <= (next_state_s == ST_LAP);
            clr_r      <= to_idle_s;
            tick_r     <= advance_s & cnt_last_s;
            if (to_idle_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (advance_s) begin
                cnt_r <= cnt_last_s ? {CW{1'b0}} : cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign tick       = tick_r;
    assign clr_digits = clr_r;
    assign running    = running_r;
    assign lap_hold   = lap_hold_r;
    assign state      = state_r;

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Bench for stopwatch_tick_ctrl (DIV=4): directed scenarios plus random button
// activity, all checked cycle by cycle against a behavioural model.
module tb_stopwatch_tick_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic       tick;
    logic       clr_digits;
    logic       running;
    logic       lap_hold;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: per-edge button samples since reset release, mode, running-cycle total.
    int edge_n = 0;
    bit hs [3][4096];
    int m_state = 0;
    int m_run = 0;
    bit m_tick = 1'b0;
    bit m_clr = 1'b0;
    // next mode indexed by [mode][event]; event 0 none, 1 clear, 2 start, 3 lap
    int nxt [4][4] = '{'{0, 0, 1, 0}, '{1, 1, 2, 3}, '{2, 0, 1, 2}, '{3, 3, 2, 1}};

    int sp_q[$];
    int lp_q[$];
    int cp_q[$];
    int q_run[$];
    int q_tick[$];
    int q_clr[$];
    int q_lapr[$];
    int q_lapf[$];

    stopwatch_tick_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .tick(tick), .clr_digits(clr_digits), .running(running),
        .lap_hold(lap_hold), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit rose(input int k);
        return (edge_n >= 4) && hs[k][edge_n-2] && !hs[k][edge_n-3];
    endfunction

    task automatic model_edge(input bit s, input bit l, input bit c);
        int w;
        bit was_run;
        edge_n++;
        hs[0][edge_n] = s;
        hs[1][edge_n] = l;
        hs[2][edge_n] = c;
        w = rose(2) ? 1 : rose(0) ? 2 : rose(1) ? 3 : 0;
        was_run = (m_state == 1) || (m_state == 3);
        m_clr = (w == 1) && (m_state == 0 || m_state == 2);
        if (m_clr) m_run = 0;
        m_tick = 1'b0;
        if (was_run && w != 2) begin
            m_run++;
            m_tick = (m_run % DIV) == 0;
        end
        m_state = nxt[m_state][w];
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_tick = 1'b0; m_clr = 1'b0; edge_n = 0;
    endtask

    task automatic compare_all();
        check_eq("state", state, m_state);
        check_eq("tick", tick, m_tick);
        check_eq("clr_digits", clr_digits, m_clr);
        check_eq("running", running, (m_state == 1) || (m_state == 3));
        check_eq("lap_hold", lap_hold, m_state == 3);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit s, input bit l, input bit c);
        start_stop = s; lap = l; clear = c;
        @(posedge clk);
        if (reset) model_edge(s, l, c);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic bit on(input int i, input int q[$]);
        foreach (q[j]) if (i == q[j] || i == q[j] + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int first_after(input int q[$], input int t);
        foreach (q[j]) if (q[j] > t) return q[j];
        return -1;
    endfunction

    task automatic run_seq(input int n);
        bit prev_run = 1'b0;
        bit prev_lap = 1'b0;
        q_run.delete(); q_tick.delete(); q_clr.delete(); q_lapr.delete(); q_lapf.delete();
        for (int i = 1; i <= n; i++) begin
            step(on(i, sp_q), on(i, lp_q), on(i, cp_q));
            if (running && !prev_run) q_run.push_back(i);
            if (lap_hold && !prev_lap) q_lapr.push_back(i);
            if (!lap_hold && prev_lap) q_lapf.push_back(i);
            if (tick) q_tick.push_back(i);
            if (clr_digits) begin
                q_clr.push_back(i);
                check_eq("clr_without_tick", tick, 0);
            end
            prev_run = running;
            prev_lap = lap_hold;
        end
        sp_q.delete(); lp_q.delete(); cp_q.delete();
    endtask

    initial begin
        int n_lap_ticks;
        bit rs, rl, rc;
        @(negedge clk);
        do_reset();

        // Start latency and tick spacing from RUN entry.
        sp_q.push_back(4);
        run_seq(20);
        check_eq("start_latency", qget(q_run, 0), 6);
        check_eq("tick_count", q_tick.size(), 3);
        check_eq("tick_1", qget(q_tick, 0), 10);
        check_eq("tick_2", qget(q_tick, 1), 14);
        check_eq("tick_3", qget(q_tick, 2), 18);

        // Pause with partial interval, resume, pause, clear.
        do_reset();
        sp_q.push_back(4); sp_q.push_back(11); sp_q.push_back(33); sp_q.push_back(47);
        cp_q.push_back(53);
        run_seq(62);
        check_eq("resume_entry", qget(q_run, 1), 35);
        check_eq("resume_tick", first_after(q_tick, 13), 37);
        check_eq("clr_count", q_clr.size(), 1);
        check_eq("clr_step", qget(q_clr, 0), 55);
        check_eq("idle_after_clear", state, 0);

        // Lap hold and ticks during lap.
        do_reset();
        sp_q.push_back(4); lp_q.push_back(8); lp_q.push_back(18);
        run_seq(30);
        check_eq("lap_rise", qget(q_lapr, 0), 10);
        check_eq("lap_fall", qget(q_lapf, 0), 20);
        n_lap_ticks = 0;
        foreach (q_tick[j]) if (q_tick[j] >= 10 && q_tick[j] < 20) n_lap_ticks++;
        check_eq("lap_ticks", n_lap_ticks, 3);

        // Simultaneous start and clear in PAUSE.
        do_reset();
        sp_q.push_back(4); sp_q.push_back(10); sp_q.push_back(16); cp_q.push_back(16);
        run_seq(30);
        check_eq("prio_clr_step", qget(q_clr, 0), 18);
        check_eq("prio_run_entries", q_run.size(), 1);
        check_eq("prio_final_state", state, 0);

        // Held start: one event, async reset mid-run, no event after release.
        do_reset();
        for (int i = 1; i <= 56; i++) step(i >= 4, 1'b0, 1'b0);
        check_eq("held_run", running, 1);
        #3 reset = 1'b0;
        #1;
        check_eq("async_state", state, 0);
        check_eq("async_running", running, 0);
        check_eq("async_tick", tick, 0);
        check_eq("async_lap_hold", lap_hold, 0);
        check_eq("async_clr", clr_digits, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("held_no_event", state, 0);

        // Random button activity.
        rs = 1'b0; rl = 1'b0; rc = 1'b0;
        start_stop = 1'b0;
        do_reset();
        for (int i = 1; i <= 1500; i++) begin
            rs = rs ^ ($urandom_range(0, 4) == 0);
            rl = rl ^ ($urandom_range(0, 5) == 0);
            rc = rc ^ ($urandom_range(0, 11) == 0);
            if (i == 750) do_reset();
            step(rs, rl, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_tick_ctrl.md
STOPWATCH_TICK_CTRL -- requirements
Module: stopwatch_tick_ctrl

Interface
REQ-001 Parameter DIV, default 100000, meaning clk cycles per count tick; legal range 2..2^24.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_stop  input  1  asynchronous push-button level; acts on its rising edge.
REQ-005 lap  input  1  asynchronous push-button level; acts on its rising edge.
REQ-006 clear  input  1  asynchronous push-button level; acts on its rising edge.
REQ-007 tick  output  1  one-cycle enable pulse; drives the carry/enable input of the least-significant digit block.
REQ-008 clr_digits  output  1  one-cycle pulse; drives the set input of every digit block, whose load value is tied to 0.
REQ-009 running  output  1  high in RUN or LAP.
REQ-010 lap_hold  output  1  high in LAP; display freezes the digit values while high.
REQ-011 state  output  2  current FSM state encoding.

Function
REQ-012 Each button shall pass a two-flop synchronizer then a rising-edge detector; the detected event shall change state and outputs at the 3rd rising clk edge after the input is first sampled high.
REQ-013 A button held high shall produce exactly one event; a further event requires the input to fall and rise again.
REQ-014 FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-015 IDLE: start -> RUN; clear -> IDLE with clr_digits pulse; lap ignored.
REQ-016 RUN: start -> PAUSE; lap -> LAP; clear ignored.
REQ-017 LAP: lap -> RUN; start -> PAUSE (lap_hold drops); clear ignored.
REQ-018 PAUSE: start -> RUN; clear -> IDLE with clr_digits pulse; lap ignored.
REQ-019 Events detected in the same cycle shall be prioritised clear > start > lap; lower-priority events that cycle shall be discarded.
REQ-020 Prescaler counter, width clog2(DIV), shall increment only in RUN or LAP, wrapping from DIV-1 to 0.
REQ-021 tick shall be high for exactly the cycle in which the counter equals DIV-1 while in RUN or LAP.
REQ-022 In PAUSE the counter shall hold its value; resuming continues the partial interval.
REQ-023 Entering IDLE shall zero the counter in the same cycle that clr_digits is asserted.
REQ-024 From RUN entry with counter 0, the first tick shall occur DIV cycles later, then every DIV cycles.
REQ-025 tick and clr_digits shall never be high in the same cycle.
REQ-026 A start event in the cycle where the counter equals DIV-1 shall suppress that tick and hold the counter at DIV-1.

Reset
REQ-027 While reset is low: state=IDLE, counter=0, synchronizer and edge flops=0, tick=0, clr_digits=0, running=0, lap_hold=0.
REQ-028 Reset assertion mid-run shall take effect immediately, without waiting for clk.
REQ-029 A button held high through reset release shall not generate an event.

Structure
REQ-030 Shared package stopwatch_pkg shall hold the state enum and the DIV default constant.
REQ-031 A sub-module btn_edge (synchronizer plus rising-edge detector) shall be instantiated once per button.
REQ-032 Output tick shall be registered; no combinational path from any button input to any output.

Verification (DIV=4)
REQ-033 Reset release, pulse start -> running=1 at 3rd edge; tick pulses 4, 8, 12 cycles after RUN entry.
REQ-034 Run 6 cycles (counter=2), start -> PAUSE, wait 20 cycles, start -> next tick 2 cycles after RUN re-entry.
REQ-035 In PAUSE, clear -> single clr_digits pulse, state=IDLE, counter=0, tick=0 that cycle.
REQ-036 In RUN, lap -> lap_hold=1 and ticks continue every 4 cycles; second lap -> lap_hold=0, state=RUN.
REQ-037 In PAUSE, start and clear rise together -> IDLE with clr_digits; start discarded; state stays IDLE afterwards.
REQ-038 Hold start high 50 cycles, then reset low mid-RUN -> outputs zero asynchronously; after release, held start produces no event.
